// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - single-issue ALU/branch execute unit with iterative shift-add multiplier
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake; inputs sampled only at accept
//   Da, Db, imm, src_imm  operand A, register operand B, immediate, B select (1=imm)
//   op, shamt             operation code, shift amount for LSR/LSL
//   set_flag              write {N,Z,V,C} into the flags register at completion
//   br_taken, uncond_br, is_lt  branch qualifiers used to form pc_select
//   out_valid             one-cycle completion pulse
//   result, pc_select     registered result and branch decision, held until next completion
//   flags                 stored {N,Z,V,C}
//   busy                  multiply in progress
module exec_unit #(
    parameter int WIDTH = 64,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Da,
    input  logic [WIDTH-1:0] Db,
    input  logic [WIDTH-1:0] imm,
    input  logic             src_imm,
    input  logic [3:0]       op,
    input  logic [SW-1:0]    shamt,
    input  logic             set_flag,
    input  logic             br_taken,
    input  logic             uncond_br,
    input  logic             is_lt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             pc_select,
    output logic [3:0]       flags,
    output logic             busy
);

    typedef enum logic {IDLE, MUL_RUN} state_t;

    localparam logic [3:0] OP_PASSB = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_LSR   = 4'd7;
    localparam logic [3:0] OP_LSL   = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;
    logic               pc_select_q, pc_select_d;
    logic [3:0]         flags_q, flags_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    // Branch/flag controls captured at MUL accept, consumed at completion.
    logic               m_setf_q, m_setf_d;
    logic               m_br_q, m_br_d;
    logic               m_unc_q, m_unc_d;
    logic               m_lt_q, m_lt_d;

    logic [WIDTH-1:0]   opb;
    logic [WIDTH:0]     add_w, sub_w;
    logic [WIDTH-1:0]   alu_res, acc_next;
    logic               alu_v, alu_c;

    // Condition uses the stored flags, i.e. the values before this op's own update.
    function automatic logic pc_of(input logic br, input logic unc, input logic lt,
                                   input logic z, input logic [3:0] fl);
        return unc ? br : (br & (lt ? (fl[3] ^ fl[1]) : z));
    endfunction

    assign opb   = src_imm ? imm : Db;
    assign add_w = {1'b0, Da} + {1'b0, opb};
    assign sub_w = {1'b0, Da} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        unique case (op)
            OP_PASSB: alu_res = opb;
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (Da[WIDTH-1] == opb[WIDTH-1]) && (alu_res[WIDTH-1] != Da[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (Da[WIDTH-1] != opb[WIDTH-1]) && (alu_res[WIDTH-1] != Da[WIDTH-1]);
            end
            OP_AND:  alu_res = Da & opb;
            OP_OR:   alu_res = Da | opb;
            OP_XOR:  alu_res = Da ^ opb;
            OP_LSR:  alu_res = Da >> shamt;
            OP_LSL:  alu_res = Da << shamt;
            default: alu_res = '0;
        endcase
    end

    // One multiplier bit per edge, LSB first; multiplicand shifts left in step.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        pc_select_d = pc_select_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        m_setf_d    = m_setf_q;
        m_br_d      = m_br_q;
        m_unc_d     = m_unc_q;
        m_lt_d      = m_lt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        state_d  = MUL_RUN;
                        acc_d    = '0;
                        mcand_d  = Da;
                        mplier_d = opb;
                        cnt_d    = '0;
                        m_setf_d = set_flag;
                        m_br_d   = br_taken;
                        m_unc_d  = uncond_br;
                        m_lt_d   = is_lt;
                    end else begin
                        result_d    = alu_res;
                        out_valid_d = 1'b1;
                        pc_select_d = pc_of(br_taken, uncond_br, is_lt, alu_res == '0, flags_q);
                        if (set_flag) begin
                            flags_d = {alu_res[WIDTH-1], alu_res == '0, alu_v, alu_c};
                        end
                    end
                end
            end
            MUL_RUN: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    result_d    = acc_next;
                    out_valid_d = 1'b1;
                    pc_select_d = pc_of(m_br_q, m_unc_q, m_lt_q, acc_next == '0, flags_q);
                    if (m_setf_q) begin
                        flags_d = {acc_next[WIDTH-1], acc_next == '0, 2'b00};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            pc_select_q <= 1'b0;
            flags_q     <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            m_setf_q    <= 1'b0;
            m_br_q      <= 1'b0;
            m_unc_q     <= 1'b0;
            m_lt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            pc_select_q <= pc_select_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            m_setf_q    <= m_setf_d;
            m_br_q      <= m_br_d;
            m_unc_q     <= m_unc_d;
            m_lt_q      <= m_lt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == MUL_RUN);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign pc_select = pc_select_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - randomized self-checking bench for exec_unit against an arithmetic reference model
module tb_exec_unit;

    localparam int W = 64;
    localparam int S = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] Da = '0, Db = '0, imm = '0;
    logic         src_imm = 1'b0;
    logic [3:0]   op = '0;
    logic [S-1:0] shamt = '0;
    logic         set_flag = 1'b0, br_taken = 1'b0, uncond_br = 1'b0, is_lt = 1'b0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         pc_select;
    logic [3:0]   flags;
    logic         busy;

    logic         s_in_valid = 1'b0;
    logic         s_in_ready;
    logic [7:0]   s_da = '0, s_db = '0;
    logic [3:0]   s_op = '0;
    logic [2:0]   s_shamt = '0;
    logic         s_set_flag = 1'b0;
    logic         s_out_valid;
    logic [7:0]   s_result;
    logic         s_pc;
    logic [3:0]   s_flags;
    logic         s_busy;

    int           n_total = 0;
    int           n_bad = 0;
    logic [3:0]   ref_flags = '0;

    always #5 clk = ~clk;

    exec_unit #(.WIDTH(W), .SW(S)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Da(Da), .Db(Db), .imm(imm), .src_imm(src_imm), .op(op), .shamt(shamt),
        .set_flag(set_flag), .br_taken(br_taken), .uncond_br(uncond_br), .is_lt(is_lt),
        .out_valid(out_valid), .result(result), .pc_select(pc_select), .flags(flags), .busy(busy)
    );

    exec_unit #(.WIDTH(8), .SW(3)) dut8 (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .Da(s_da), .Db(s_db), .imm(8'h00), .src_imm(1'b0), .op(s_op), .shamt(s_shamt),
        .set_flag(s_set_flag), .br_taken(1'b0), .uncond_br(1'b0), .is_lt(1'b0),
        .out_valid(s_out_valid), .result(s_result), .pc_select(s_pc), .flags(s_flags), .busy(s_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic signed [127:0] sext(input logic [63:0] x);
        return $signed({{64{x[63]}}, x});
    endfunction

    function automatic void model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                                  input logic [5:0] sh, output logic [63:0] r, output logic [3:0] f);
        logic signed [127:0] s;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (o)
            4'd0: r = b;
            4'd2: begin r = a + b; c = (r < a); s = sext(a) + sext(b); v = (s != sext(r)); end
            4'd3: begin r = a - b; c = (a >= b); s = sext(a) - sext(b); v = (s != sext(r)); end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = a >> sh;
            4'd8: r = a << sh;
            4'd9: r = a * b;
            default: r = '0;
        endcase
        f = {r[63], r == 64'd0, v, c};
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] im, input logic si, input logic [5:0] sh,
                          input logic sf, input logic br, input logic unc, input logic lt);
        logic [63:0] bop, er;
        logic [3:0]  ef;
        logic        epc;
        int          lat;
        bop = si ? im : b;
        model(o, a, bop, sh, er, ef);
        epc = unc ? br : (br & (lt ? (ref_flags[3] ^ ref_flags[1]) : (er == 64'd0)));
        @(negedge clk);
        check_eq("in_ready_idle", in_ready, 1'b1);
        op = o; Da = a; Db = b; imm = im; src_imm = si; shamt = sh;
        set_flag = sf; br_taken = br; uncond_br = unc; is_lt = lt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < W + 10) begin
            check_eq("mul_busy", busy, 1'b1);
            check_eq("mul_not_ready", in_ready, 1'b0);
            // Junk issued during the run must be dropped.
            in_valid = 1'($urandom_range(0, 1));
            op = 4'($urandom);
            Da = {$urandom, $urandom};
            Db = {$urandom, $urandom};
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check_eq("latency", lat, (o == 4'd9) ? W + 1 : 1);
        check_eq("result", result, er);
        check_eq("pc_select", pc_select, epc);
        if (sf) ref_flags = ef;
        check_eq("flags", flags, ref_flags);
        check_eq("ready_at_done", in_ready, 1'b1);
        @(posedge clk); #1;
        check_eq("ov_pulse", out_valid, 1'b0);
        check_eq("result_hold", result, er);
    endtask

    initial begin
        int seen;
        int lat;
        logic [3:0]  o;
        logic [63:0] a, b;

        #1;
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_ov", out_valid, 1'b0);
        check_eq("rst_flags", flags, 4'd0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        run_op(4'd3, 64'd5, 64'd7, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("sub_5_7", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("sub_flags", flags, 4'b1000);

        run_op(4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("add_ovf", result, 64'h8000_0000_0000_0000);
        check_eq("add_ovf_flags", flags, 4'b1010);
        run_op(4'd0, 64'd3, 64'd9, 64'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("blt_not_taken", pc_select, 1'b0);

        run_op(4'd9, 64'h12345, 64'h100, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("mul_dir", result, 64'h123_4500);

        run_op(4'd0, 64'd77, 64'd0, 64'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("cbz_taken", pc_select, 1'b1);
        run_op(4'd5, 64'h55, 64'hAA, 64'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("uncond_taken", pc_select, 1'b1);

        for (int i = 0; i < 150; i++) begin
            o = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) o = 4'd9;
            case ($urandom_range(0, 5))
                0: a = 64'd0;
                1: a = '1;
                2: a = 64'h8000_0000_0000_0000;
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0: b = 64'd0;
                1: b = 64'h7FFF_FFFF_FFFF_FFFF;
                2: b = 64'({$urandom_range(0, 3)});
                default: b = {$urandom, $urandom};
            endcase
            run_op(o, a, b, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 6'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abort a multiply mid-run.
        @(negedge clk);
        op = 4'd9; Da = {$urandom, $urandom}; Db = {$urandom, $urandom}; src_imm = 1'b0;
        set_flag = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_eq("abort_result", result, 64'd0);
        check_eq("abort_ov", out_valid, 1'b0);
        check_eq("abort_pc", pc_select, 1'b0);
        check_eq("abort_flags", flags, 4'd0);
        check_eq("abort_busy", busy, 1'b0);
        ref_flags = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_rst", in_ready, 1'b1);
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("no_ov_after_abort", seen, 0);
        run_op(4'd2, 64'd1, 64'd1, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("add_after_rst", result, 64'd2);

        // Narrow instance.
        @(negedge clk);
        s_op = 4'd8; s_da = 8'h81; s_shamt = 3'd1; s_set_flag = 1'b0; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check_eq("w8_lsl_ov", s_out_valid, 1'b1);
        check_eq("w8_lsl", s_result, 8'h02);
        @(negedge clk);
        s_op = 4'd9; s_da = 8'h10; s_db = 8'h10; s_set_flag = 1'b1; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("w8_mul_lat", lat, 9);
        check_eq("w8_mul", s_result, 8'h00);
        check_eq("w8_mul_flags", s_flags, 4'b0100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter WIDTH, default 64: datapath width; legal values are powers of two from 8 to 64.
REQ-002 Parameter SW, default $clog2(WIDTH): shift-amount width.
REQ-003 Port clk  in  1  rising-edge clock; the block has one clock.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port in_valid  in  1  operation presented.
REQ-006 Port in_ready  out  1  block can accept an operation.
REQ-007 Ports Da, Db, imm  in  WIDTH each  operand A, register operand B, pre-extended immediate.
REQ-008 Port src_imm  in  1  operand B select: 1=imm, 0=Db.
REQ-009 Port op  in  4  operation code: 0 PASSB, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 LSR, 8 LSL, 9 MUL; all other codes are reserved.
REQ-010 Port shamt  in  SW  shift amount for LSR/LSL.
REQ-011 Ports set_flag, br_taken, uncond_br, is_lt  in  1 each  flag-write enable, branch instruction, unconditional branch, condition select (1=LT, 0=CBZ).
REQ-012 Port out_valid  out  1  one-cycle completion pulse.
REQ-013 Port result  out  WIDTH  registered result.
REQ-014 Port pc_select  out  1  registered branch decision, qualified by out_valid.
REQ-015 Port flags  out  4  stored {N,Z,V,C}.
REQ-016 Port busy  out  1  multiply in progress.

Function
REQ-017 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; the block SHALL sample all inputs only at accept.
REQ-018 in_ready SHALL equal (state==IDLE).
REQ-019 busy SHALL equal (state==MUL_RUN).
REQ-020 Operand B SHALL be src_imm ? imm : Db.
REQ-021 ADD: result = A+B mod 2^WIDTH; C = carry-out; V = signed overflow.
REQ-022 SUB: result = A+~B+1; C = carry-out (1 = no borrow); V = signed overflow.
REQ-023 Logic ops, PASSB, LSR (logical) and LSL: V=0, C=0.
REQ-024 For every op, N = result[WIDTH-1] and Z = (result==0).
REQ-025 Reserved op codes: result=0, N=0, Z=1, V=0, C=0, single-cycle timing.
REQ-026 Single-cycle ops: result, out_valid=1 and pc_select SHALL appear on the edge of accept (latency 1); the FSM SHALL stay in IDLE.
REQ-027 MUL: accept SHALL enter MUL_RUN; each edge SHALL process one multiplier bit (shift-add, LSB first); after WIDTH iteration edges, result = low WIDTH bits of A*B, out_valid pulses, and the FSM returns to IDLE; V=0, C=0.
REQ-028 MUL latency SHALL be WIDTH+1 edges from accept to the out_valid edge.
REQ-029 in_ready SHALL be 1 in the out_valid cycle of a MUL, so back-to-back issue is possible.
REQ-030 out_valid SHALL be a single-cycle pulse; result and pc_select SHALL hold their values until the next completion.
REQ-031 The flags register SHALL update with the op's {N,Z,V,C} on the completion edge only when set_flag was 1 at accept.
REQ-032 Branch condition: is_lt ? (stored N XOR stored V) : Z of this op's result. Stored flags are the values before this op's own flag update.
REQ-033 pc_select SHALL be uncond_br ? br_taken : (br_taken AND condition).
REQ-034 in_valid during MUL_RUN SHALL be ignored and SHALL NOT be queued.
REQ-035 SHALL apply only at legal values; behaviour at shamt >= WIDTH is not required for WIDTH < 2^SW.

Reset
REQ-036 reset=0 SHALL asynchronously force: state=IDLE, result=0, out_valid=0, pc_select=0, flags=0, busy=0, and the multiply accumulator/counter to 0.
REQ-037 reset asserted during MUL_RUN SHALL abort the operation with no out_valid pulse; in_ready=1 on the first edge after reset is released.

Verification
REQ-038 WIDTH=64, SUB Da=5, Db=7, set_flag=1 -> 1 cycle later: result=0xFFFFFFFFFFFFFFFE, out_valid=1, flags N=1 Z=0 V=0 C=0.
REQ-039 ADD Da=0x7FFFFFFFFFFFFFFF, imm=1, src_imm=1, set_flag=1 -> result=0x8000000000000000, flags N=1 V=1 C=0; then is_lt=1, br_taken=1 -> pc_select=0 (N^V=0).
REQ-040 MUL Da=0x12345, Db=0x100 -> in_ready=0 and busy=1 for 64 cycles; out_valid exactly 65 edges after accept; result=0x1234500; in_valid pulses during the run are ignored.
REQ-041 CBZ: PASSB Db=0, br_taken=1, is_lt=0 -> pc_select=1; with uncond_br=1, br_taken=1 and any data -> pc_select=1.
REQ-042 Reset pulse 20 cycles into a MUL -> outputs 0 immediately; no out_valid; a subsequent ADD 1+1 -> result=2.
REQ-043 WIDTH=8: LSL Da=0x81, shamt=1 -> result=0x02; MUL 0x10*0x10 -> result=0x00 with Z=1, latency 9 edges.
